execute_div_ctrl: RTL and testbench

- Multi-cycle divide sequencer beside the execute stage; implements the RV32M DIV/DIVU/REM/REMU ops the single-cycle ALU does not cover.
- Owns an iterative restoring shift-subtract datapath and the FSM that sequences it.
- Holds the pipeline (stall) while iterating, then presents one registered result for the execute-to-memory transfer.

---
 rtl/execute_div_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_execute_div_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : execute_div_ctrl
//  Purpose  : Multi-cycle RV32M divide sequencer sitting beside the execute
//             stage. Handles DIV/DIVU/REM/REMU with an iterative restoring
//             shift-subtract datapath (one quotient bit per cycle), stalls
//             the front of the pipeline while iterating, and presents one
//             registered result pulse for the execute-to-memory transfer.
//  Ports    : clk, reset_n         - rising-edge clock, async active-low reset
//             start, op            - request (sampled in IDLE) and opcode
//                                    (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//             dividend, divisor    - rs1 / rs2 after forwarding
//             flush                - abort any operation in flight
//             busy                 - registered, high in CALC or DONE
//             stall                - combinational hold for IF/ID/EX regs
//             result_valid, result - registered one-cycle result pulse
//  Revision : 1.0 - initial release
// ============================================================================
module execute_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_zero    = '0;
    localparam logic [WIDTH-1:0] c_ones    = '1;
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_min_int = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH-1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             state_q,        state_d;
    logic [CNT_W-1:0]   counter_q,      counter_d;
    logic [1:0]         op_q,           op_d;
    logic               sign_a_q,       sign_a_d;   // dividend negative (signed ops only)
    logic               sign_b_q,       sign_b_d;   // divisor negative (signed ops only)
    logic [WIDTH:0]     rem_q,          rem_d;      // extra bit for compare/subtract
    logic [WIDTH-1:0]   quo_q,          quo_d;      // holds |dividend|, shifts into quotient
    logic [WIDTH-1:0]   dvs_q,          dvs_d;      // |divisor|
    logic               busy_q,         busy_d;
    logic               result_valid_q, result_valid_d;
    logic [WIDTH-1:0]   result_q,       result_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_shift;
    logic               w_fits;
    logic [WIDTH:0]     w_rem_step;
    logic [WIDTH-1:0]   w_quo_step;
    logic [WIDTH-1:0]   w_q_final;
    logic [WIDTH-1:0]   w_r_final;
    logic               w_q_neg;

    always_comb begin
        // Operand classification for a new request
        w_signed = ~op[0];
        w_a_neg  = w_signed & dividend[WIDTH-1];
        w_b_neg  = w_signed & divisor[WIDTH-1];
        w_abs_a  = w_a_neg ? (~dividend + c_one) : dividend;
        w_abs_b  = w_b_neg ? (~divisor  + c_one) : divisor;

        // One restoring step: shift {rem,quo} left, trial-subtract divisor
        w_shift    = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
        w_fits     = (w_shift >= {1'b0, dvs_q});
        w_rem_step = w_fits ? (w_shift - {1'b0, dvs_q}) : w_shift;
        w_quo_step = {quo_q[WIDTH-2:0], w_fits};

        // Sign fix-up applied on the last step so the result can be registered
        w_q_neg   = ~op_q[0] & (sign_a_q ^ sign_b_q);
        w_q_final = w_q_neg  ? (~w_quo_step + c_one) : w_quo_step;
        w_r_final = sign_a_q ? (~w_rem_step[WIDTH-1:0] + c_one)
                             : w_rem_step[WIDTH-1:0];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        op_d      = op_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = op;
                    sign_a_d = w_a_neg;
                    sign_b_d = w_b_neg;
                    if (divisor == c_zero) begin
                        // Divide by zero: quotient all ones, remainder = dividend
                        state_d  = S_DONE;
                        result_d = op[1] ? dividend : c_ones;
                    end else if (w_signed && (dividend == c_min_int) && (divisor == c_ones)) begin
                        // Signed overflow: MIN_INT / -1
                        state_d  = S_DONE;
                        result_d = op[1] ? c_zero : c_min_int;
                    end else begin
                        state_d   = S_CALC;
                        counter_d = '0;
                        rem_d     = '0;
                        quo_d     = w_abs_a;
                        dvs_d     = w_abs_b;
                    end
                end
            end
            S_CALC: begin
                rem_d     = w_rem_step;
                quo_d     = w_quo_step;
                counter_d = counter_q + c_cnt_one;
                if (counter_q == c_last) begin
                    state_d   = S_DONE;
                    counter_d = '0;
                    result_d  = op_q[1] ? w_r_final : w_q_final;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush overrides everything, including a request in the same cycle
        if (flush) begin
            state_d   = S_IDLE;
            counter_d = '0;
            result_d  = result_q;
        end

        busy_d         = (state_d != S_IDLE);
        result_valid_d = (state_d == S_DONE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            counter_q      <= '0;
            op_q           <= '0;
            sign_a_q       <= 1'b0;
            sign_b_q       <= 1'b0;
            rem_q          <= '0;
            quo_q          <= '0;
            dvs_q          <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            op_q           <= op_d;
            sign_a_q       <= sign_a_d;
            sign_b_q       <= sign_b_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            dvs_q          <= dvs_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            result_q       <= result_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Stall is released in DONE so the pipeline advances with the result.
    assign stall        = ((state_q == S_IDLE) & start & ~flush) | (state_q == S_CALC);
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute_div_ctrl
//  Purpose  : Scoreboard bench for execute_div_ctrl. Stimulus pushes the
//             reference result and expected arrival cycle into a queue; a
//             monitor pops on every result_valid pulse and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_execute_div_ctrl;

    localparam int WIDTH = 32;
    localparam int LAT_NORMAL = WIDTH + 1;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  dividend;
    logic [WIDTH-1:0]  divisor;
    logic              flush;
    logic              busy;
    logic              stall;
    logic              result_valid;
    logic [WIDTH-1:0]  result;

    execute_div_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .op           (op),
        .dividend     (dividend),
        .divisor      (divisor),
        .flush        (flush),
        .busy         (busy),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: plain SystemVerilog arithmetic on wide signed ints.
    function automatic logic [WIDTH-1:0] ref_div(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        longint sa, sb_v;
        if (b == 0) return o[1] ? a : {WIDTH{1'b1}};
        if (!o[0]) begin
            sa   = longint'($signed(a));
            sb_v = longint'($signed(b));
            return o[1] ? WIDTH'(sa % sb_v) : WIDTH'(sa / sb_v);
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return LAT_NORMAL;
    endfunction

    // Monitor: compare every result pulse with the scoreboard head, and
    // check that the pulse lasts one cycle with the result held afterwards.
    logic             prev_valid = 1'b0;
    logic [WIDTH-1:0] prev_result = '0;
    always @(negedge clk) begin
        if (reset_n && prev_valid) begin
            chk("valid_drop", {31'd0, result_valid}, 32'd0);
            chk("result_hold", result, prev_result);
        end
        if (reset_n && result_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {31'd0, result_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("latency_cycle", WIDTH'(cyc), WIDTH'(e.cyc));
            end
        end
        prev_valid  = reset_n && result_valid;
        prev_result = result;
    end

    // Caller is #1 after a rising edge; start is held one (or two) cycles.
    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input bit hold2);
        exp_t e;
        e.res = ref_div(o, a, b);
        e.cyc = cyc + ref_lat(o, a, b);
        sb.push_back(e);
        start = 1'b1; op = o; dividend = a; divisor = b;
        @(posedge clk); #1;
        if (hold2) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", WIDTH'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [1:0]       ro;
        logic [WIDTH-1:0] ra, rb;

        reset_n = 1'b0; start = 1'b0; op = 2'b00;
        dividend = '0; divisor = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, result_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // DIVU 100/7 with stall / busy timing
        t0 = cyc;
        begin
            exp_t e;
            e.res = 32'd14; e.cyc = t0 + 33;
            sb.push_back(e);
        end
        start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
        for (int i = 0; i <= 33; i++) begin
            @(negedge clk);
            chk("stall_window", {31'd0, stall}, (i < 33) ? 32'd1 : 32'd0);
            if (i == 1) chk("busy_calc", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
        end
        @(negedge clk);
        chk("busy_after", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Directed signed / special cases
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);          drain(60);
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);          drain(60);
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  drain(60);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  drain(60);
        issue(2'b01, 32'd5, 32'd0, 1'b1);                  drain(60);
        issue(2'b11, 32'd5, 32'd0, 1'b0);                  drain(60);
        issue(2'b00, 32'd7, 32'hFFFF_FFFE, 1'b0);          drain(60);
        issue(2'b00, 32'd1, 32'd0, 1'b0);                  drain(60);

        // Flush mid-CALC, then a fresh REMU
        t0 = cyc;
        start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < t0 + 10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_valid", {31'd0, result_valid}, 32'd0);
        issue(2'b11, 32'd100, 32'd7, 1'b0);
        drain(60);

        // start and flush together in IDLE: nothing accepted
        start = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        chk("flush_start_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-CALC
        t0 = cyc;
        start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < t0 + 20) begin @(posedge clk); #1; end
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("areset_busy",   {31'd0, busy}, 32'd0);
        chk("areset_valid",  {31'd0, result_valid}, 32'd0);
        chk("areset_result", result, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Randomized operations, with ignored start pulses during CALC
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       begin ra = $urandom; rb = '0; end
                1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2:       begin ra = $urandom; rb = 32'($urandom_range(1, 20)); end
                3:       begin ra = 32'($urandom_range(0, 50)); rb = $urandom; end
                default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
            endcase
            if (rb == 0 && $urandom_range(0, 1) == 1) rb = 32'd3;
            issue(ro, ra, rb, 1'($urandom_range(0, 1)));
            if (ref_lat(ro, ra, rb) == LAT_NORMAL && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 25)) @(posedge clk);
                #1;
                start = 1'b1; op = 2'($urandom_range(0, 3));
                dividend = $urandom; divisor = $urandom;
                @(posedge clk); #1;
                start = 1'b0;
            end
            drain(80);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
